// File: rtl/iob2axi_burst_split.sv
// rtl/iob2axi_burst_split.sv - splits a transfer command into AXI-legal bursts (<=MAX_BURST beats, no 4 KB crossing)
// Optional abort-on-error: define IOB2AXI_BURST_SPLIT_ABORT_EN
module iob2axi_burst_split #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 16,
  parameter int MAX_BURST = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                cmd_wr,
  output logic                done,
  output logic                error,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                wr_valid,
  output logic                wr_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [7:0]          m_length,
  input  logic                m_ctrl_ready,
  input  logic                m_error,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready
);

  localparam int BYTES = DATA_W / 8;
  localparam int LOG2B = $clog2(BYTES);
  localparam int CW    = ((LEN_W > 13) ? LEN_W : 13) + 1;
  localparam logic [CW-1:0] MAXB = CW'(MAX_BURST);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CALC = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_XFER = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic              wr;
  logic [8:0]        beats;
  logic [8:0]        beat_cnt;
  logic [7:0]        length_r;
  logic              error_r;

  logic [12:0]       words_to_4k;
  logic [CW-1:0]     beats_c;
  logic [ADDR_W-1:0] burst_bytes;
  logic              in_xfer;
  logic              beat_fire;
  logic              last_beat;
  logic              stop_c;

  // words left before the next 4 KB page; 4096 itself needs the 13th bit
  assign words_to_4k = 13'((14'd4096 - {2'b00, addr[11:0]}) >> LOG2B);
  assign burst_bytes = ADDR_W'(beats) << LOG2B;

  always_comb begin
    beats_c = CW'(remaining);
    if (CW'(words_to_4k) < beats_c) beats_c = CW'(words_to_4k);
    if (MAXB < beats_c)             beats_c = MAXB;
  end

  assign in_xfer   = (state == S_XFER);
  assign m_valid   = in_xfer & (wr ? wr_valid : rd_ready);
  assign wr_ready  = in_xfer & wr & m_ready;
  assign rd_valid  = in_xfer & ~wr & m_ready;
  assign rd_data   = (in_xfer & ~wr) ? m_rdata : '0;
  assign m_wdata   = (in_xfer & wr) ? wr_data : '0;
  assign m_wstrb   = (in_xfer & wr) ? '1 : '0;
  assign cmd_ready = (state == S_IDLE);
  assign done      = (state == S_DONE);
  assign m_addr    = addr;
  assign m_length  = length_r;
  assign error     = error_r;

  assign beat_fire = in_xfer & m_valid & m_ready;
  assign last_beat = beat_fire & (beat_cnt == 9'd1);

`ifdef IOB2AXI_BURST_SPLIT_ABORT_EN
  logic abort;

  // an error seen anywhere in this burst, including its final beat, stops further bursts
  assign stop_c = abort | m_error;

  always_ff @(posedge clk) begin
    if (rst) begin
      abort <= 1'b0;
    end else if (state == S_IDLE && cmd_valid) begin
      abort <= 1'b0;
    end else if (in_xfer && m_error) begin
      abort <= 1'b1;
    end
  end
`else
  assign stop_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      wr        <= 1'b0;
      beats     <= '0;
      beat_cnt  <= '0;
      length_r  <= '0;
      error_r   <= 1'b0;
    end else begin
      if (state != S_IDLE && m_error) error_r <= 1'b1;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr      <= cmd_addr;
            remaining <= cmd_len;
            wr        <= cmd_wr;
            error_r   <= 1'b0;
            state     <= (cmd_len == '0) ? S_DONE : S_CALC;
          end
        end
        S_CALC: begin
          length_r <= 8'(beats_c - CW'(1));
          beats    <= 9'(beats_c);
          beat_cnt <= 9'(beats_c);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (m_ctrl_ready) state <= S_XFER;
        end
        S_XFER: begin
          if (beat_fire) begin
            beat_cnt  <= beat_cnt - 9'd1;
            remaining <= remaining - LEN_W'(1);
          end
          if (last_beat) begin
            addr  <= addr + burst_bytes;
            state <= (remaining == LEN_W'(1) || stop_c) ? S_DONE : S_CALC;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob2axi_burst_split.sv
// tb/tb_iob2axi_burst_split.sv - directed vector bench for iob2axi_burst_split
module tb_iob2axi_burst_split;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_wr, done, error;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic [31:0] wr_data, rd_data, m_addr, m_wdata, m_rdata;
  logic        wr_valid, wr_ready, rd_valid, rd_ready;
  logic [7:0]  m_length;
  logic        m_ctrl_ready, m_error, m_valid, m_ready;
  logic [3:0]  m_wstrb;

  always #5 clk = ~clk;

  iob2axi_burst_split dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_wr(cmd_wr), .done(done), .error(error),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .m_length(m_length), .m_ctrl_ready(m_ctrl_ready), .m_error(m_error),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // bench state shared between the bus model and the test sequence
  int          wr_idx = 0;
  int          bcnt   = 0;
  bit          rnd_en = 1'b0;
  bit          err_arm = 1'b0;
  bit          cur_wr = 1'b0;
  logic [31:0] cur_base;
  logic [7:0]  cur_len;
  int done_cnt, done_cyc, beat_total, last_beat_cyc, addr_bad, strb_bad, cross_bad;
  logic [31:0] bbase_q[$];
  logic [7:0]  blen_q[$];
  logic [31:0] wdat_q[$];
  logic [31:0] rdat_q[$];

  // memory model: the word at byte address a reads back as ~a
  assign wr_data = 32'hC000_0000 + 32'(wr_idx);
  assign m_rdata = ~(m_addr + 32'(bcnt) * 32'd4);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    bbase_q.delete(); blen_q.delete(); wdat_q.delete(); rdat_q.delete();
    done_cnt = 0; done_cyc = 0; beat_total = 0; last_beat_cyc = 0;
    addr_bad = 0; strb_bad = 0; cross_bad = 0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // bridge / stream model: observe at negedge, drive just after posedge
  initial forever begin
    int nb;
    bit adv_wr;
    @(negedge clk);
    nb = bcnt;
    adv_wr = 1'b0;
    if (rst) begin
      nb = 0;
    end else begin
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (m_valid && m_ready) begin
        if (bcnt == 0) begin cur_base = m_addr; cur_len = m_length; end
        if (m_addr != cur_base) addr_bad++;
        if (m_wstrb != (cur_wr ? 4'hF : 4'h0)) strb_bad++;
        if (cur_wr) wdat_q.push_back(m_wdata);
        beat_total++;
        last_beat_cyc = cyc;
        nb = bcnt + 1;
        if (nb == int'(cur_len) + 1) begin
          bbase_q.push_back(cur_base);
          blen_q.push_back(cur_len);
          if (int'(cur_base[11:0]) + nb * 4 > 4096) cross_bad++;
          nb = 0;
        end
      end
      if (rd_valid && rd_ready) rdat_q.push_back(rd_data);
      if (wr_valid && wr_ready) adv_wr = 1'b1;
    end
    @(posedge clk);
    #1;
    bcnt = nb;
    if (adv_wr) wr_idx++;
    if (err_arm && beat_total >= 3) begin
      m_error = 1'b1;
      err_arm = 1'b0;
    end else begin
      m_error = 1'b0;
    end
    if (rnd_en) begin
      wr_valid     = ($urandom_range(0, 3) != 0);
      rd_ready     = ($urandom_range(0, 3) != 0);
      m_ready      = ($urandom_range(0, 3) != 0);
      m_ctrl_ready = ($urandom_range(0, 1) != 0);
    end else begin
      wr_valid = 1'b1; rd_ready = 1'b1; m_ready = 1'b1; m_ctrl_ready = 1'b1;
    end
  end

  int acc_cyc;

  task automatic issue_cmd(input logic w, input logic [31:0] a, input logic [15:0] l);
    clear_logs();
    cur_wr = w;
    for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_wr = w;
    @(posedge clk); #1;
    acc_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input string name, input logic w, input logic [31:0] a, input logic [15:0] l);
    issue_cmd(w, a, l);
    for (int i = 0; i < 8000 && done_cnt == 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check({name, "_done_once"}, 64'(done_cnt), 64'd1);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [15:0] len;
    int          nb;
    logic [7:0]  len0;
    logic [31:0] addr0;
    logic [7:0]  lenl;
    logic [31:0] addrl;
  } vec_t;

  vec_t vt[8];

  initial begin
    int bad;
    vt[0] = '{1'b1, 32'h0000_0000, 16'd4,   1, 8'd3,   32'h0000_0000, 8'd3,  32'h0000_0000};
    vt[1] = '{1'b0, 32'h0000_0000, 16'd600, 3, 8'd255, 32'h0000_0000, 8'd87, 32'h0000_0800};
    vt[2] = '{1'b1, 32'h0000_0FF8, 16'd4,   2, 8'd1,   32'h0000_0FF8, 8'd1,  32'h0000_1000};
    vt[3] = '{1'b0, 32'h0000_0F00, 16'd100, 2, 8'd63,  32'h0000_0F00, 8'd35, 32'h0000_1000};
    vt[4] = '{1'b1, 32'h0000_0004, 16'd1,   1, 8'd0,   32'h0000_0004, 8'd0,  32'h0000_0004};
    vt[5] = '{1'b0, 32'h0000_0000, 16'd256, 1, 8'd255, 32'h0000_0000, 8'd255, 32'h0000_0000};
    vt[6] = '{1'b1, 32'h0000_0400, 16'd257, 2, 8'd255, 32'h0000_0400, 8'd0,  32'h0000_0800};
    vt[7] = '{1'b0, 32'hFFFF_FFF8, 16'd4,   2, 8'd1,   32'hFFFF_FFF8, 8'd1,  32'h0000_0000};

    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_wr = 1'b0;
    wr_valid = 1'b0; rd_ready = 1'b0; m_ready = 1'b0; m_ctrl_ready = 1'b0; m_error = 1'b0;
    clear_logs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {63'd0, cmd_ready}, 64'd1);
    check("reset_outs", 64'({m_valid, wr_ready, rd_valid, done, error, m_wstrb, m_length}), 64'd0);
    check("reset_addr", 64'(m_addr), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    rnd_en = 1'b1;
    for (int v = 0; v < 8; v++) begin
      run_cmd($sformatf("v%0d", v), vt[v].wr, vt[v].addr, vt[v].len);
      check($sformatf("v%0d_nbursts", v), 64'(bbase_q.size()), 64'(vt[v].nb));
      check($sformatf("v%0d_len0", v), 64'((blen_q.size() > 0) ? blen_q[0] : 8'hXX), 64'(vt[v].len0));
      check($sformatf("v%0d_addr0", v), 64'((bbase_q.size() > 0) ? bbase_q[0] : 32'hXXXX_XXXX), 64'(vt[v].addr0));
      check($sformatf("v%0d_lenl", v), 64'((blen_q.size() > 0) ? blen_q[blen_q.size()-1] : 8'hXX), 64'(vt[v].lenl));
      check($sformatf("v%0d_addrl", v), 64'((bbase_q.size() > 0) ? bbase_q[bbase_q.size()-1] : 32'hXXXX_XXXX), 64'(vt[v].addrl));
      check($sformatf("v%0d_beats", v), 64'(beat_total), 64'(vt[v].len));
      check($sformatf("v%0d_addr_stable", v), 64'(addr_bad), 64'd0);
      check($sformatf("v%0d_wstrb", v), 64'(strb_bad), 64'd0);
      check($sformatf("v%0d_no_4k_cross", v), 64'(cross_bad), 64'd0);
      check($sformatf("v%0d_done_lat", v), 64'(done_cyc - last_beat_cyc), 64'd1);
      check($sformatf("v%0d_error", v), {63'd0, error}, 64'd0);
      bad = 0;
      if (vt[v].wr) begin
        for (int k = 0; k < wdat_q.size(); k++)
          if (wdat_q[k] != 32'hC000_0000 + 32'(wr_idx - int'(vt[v].len) + k)) bad++;
        check($sformatf("v%0d_wcount", v), 64'(wdat_q.size()), 64'(vt[v].len));
      end else begin
        for (int k = 0; k < rdat_q.size(); k++)
          if (rdat_q[k] != ~(vt[v].addr + 32'(k) * 32'd4)) bad++;
        check($sformatf("v%0d_rcount", v), 64'(rdat_q.size()), 64'(vt[v].len));
      end
      check($sformatf("v%0d_data", v), 64'(bad), 64'd0);
      if (v == 1) begin
        check("v1_mid_addr", 64'((bbase_q.size() > 1) ? bbase_q[1] : 32'hXXXX_XXXX), 64'h400);
        check("v1_mid_len", 64'((blen_q.size() > 1) ? blen_q[1] : 8'hXX), 64'd255);
      end
    end

    // zero-length command: no beats, done right after accept, then idle again
    run_cmd("len0", 1'b1, 32'h100, 16'd0);
    check("len0_beats", 64'(beat_total), 64'd0);
    check("len0_done_lat", 64'(done_cyc - acc_cyc), 64'd0);
    check("len0_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // reset in the middle of a 16-beat write burst
    rnd_en = 1'b0;
    issue_cmd(1'b1, 32'h0, 16'd16);
    for (int i = 0; i < 200 && beat_total < 5; i++) @(negedge clk);
    check("mid_rst_reached_xfer", 64'(beat_total >= 5), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1; cmd_valid = 1'b1; cmd_addr = 32'h80; cmd_len = 16'd0; cmd_wr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_ctrl", {63'd0, cmd_ready}, 64'd1);
    check("mid_rst_outs", 64'({m_valid, wr_ready, rd_valid, done, error, m_wstrb, m_length}), 64'd0);
    check("mid_rst_addr", 64'(m_addr), 64'd0);
    @(negedge clk);
    check("rst_beats_cmd", 64'({cmd_ready, done}), 64'b10);
    @(posedge clk); #1;
    rst = 1'b0; cmd_valid = 1'b0;
    run_cmd("post_rst", 1'b1, 32'h40, 16'd2);
    check("post_rst_nbursts", 64'(bbase_q.size()), 64'd1);
    check("post_rst_len", 64'((blen_q.size() > 0) ? blen_q[0] : 8'hXX), 64'd1);
    check("post_rst_addr", 64'((bbase_q.size() > 0) ? bbase_q[0] : 32'hXXXX_XXXX), 64'h40);

    // bridge error during the first burst of a 3-burst read
    rnd_en = 1'b1;
    err_arm = 1'b1;
    run_cmd("err", 1'b0, 32'h0, 16'd600);
`ifdef IOB2AXI_BURST_SPLIT_ABORT_EN
    check("err_nbursts", 64'(bbase_q.size()), 64'd1);
`else
    check("err_nbursts", 64'(bbase_q.size()), 64'd3);
`endif
    check("err_sticky", {63'd0, error}, 64'd1);
    issue_cmd(1'b0, 32'h0, 16'd1);
    @(negedge clk);
    check("err_cleared", {63'd0, error}, 64'd0);
    for (int i = 0; i < 200 && done_cnt == 0; i++) @(negedge clk);
    check("err_next_done", 64'(done_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
